// File: rtl/multu_unit_pkg.sv
// Shared definitions for the iterative MULTU unit: FSM state encoding and
// HI/LO select values used by the MFHI/MFLO read mux.
package multu_unit_pkg;

   typedef enum logic [1:0] {
      MU_IDLE = 2'd0,
      MU_RUN  = 2'd1,
      MU_DONE = 2'd2
   } mu_state_t;

   localparam logic HILO_SEL_LO = 1'b0;
   localparam logic HILO_SEL_HI = 1'b1;

endpackage

// File: rtl/multu_unit.sv
// EX-stage shift-add unsigned multiplier owning the HI/LO pair; retires one
// multiplier bit per cycle and holds the pipeline via stall until HI/LO commit.
module multu_unit
   import multu_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_sel,
   output logic [WIDTH-1:0] hilo_out,
   output logic             stall,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mu_state_t          state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   mcand_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               done_reg;

   logic [WIDTH:0]     upper_sum;
   logic [2*WIDTH-1:0] acc_next;

   // The carry out of the upper half is kept and shifted in as the new MSB.
   always_comb begin
      upper_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
      if (acc_reg[0])
         acc_next = {upper_sum, acc_reg[WIDTH-1:1]};
      else
         acc_next = {1'b0, acc_reg[2*WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= MU_IDLE;
         cnt_reg   <= '0;
         mcand_reg <= '0;
         acc_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else if (flush) begin
         // Squash: abandon any in-flight product, HI/LO untouched.
         state_reg <= MU_IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            MU_IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  mcand_reg <= a;
                  acc_reg   <= {{WIDTH{1'b0}}, b};
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= MU_RUN;
               end
            end
            MU_RUN: begin
               acc_reg <= acc_next;
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_LAST) begin
                  hi_reg    <= acc_next[2*WIDTH-1:WIDTH];
                  lo_reg    <= acc_next[WIDTH-1:0];
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= MU_DONE;
               end
            end
            MU_DONE: begin
               // start here still belongs to the instruction just retired.
               done_reg  <= 1'b0;
               state_reg <= MU_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= MU_IDLE;
            end
         endcase
      end
   end

   assign stall    = ((state_reg == MU_IDLE) && start) || (state_reg == MU_RUN);
   assign hilo_out = (hilo_sel == HILO_SEL_HI) ? hi_reg : lo_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_multu_unit.sv
// Directed bench for multu_unit: hand-computed products, stall length,
// operand capture, back-to-back issue, async reset and flush aborts.
module tb_multu_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [31:0] a;
   logic [31:0] b;
   logic        hilo_sel;
   logic [31:0] hilo_out;
   logic        stall;
   logic        busy;
   logic        done;

   int errors;
   int checks;
   int done_cnt;

   multu_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .flush    (flush),
      .a        (a),
      .b        (b),
      .hilo_sel (hilo_sel),
      .hilo_out (hilo_out),
      .stall    (stall),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      hilo_sel = 1'b0; #1;
      chk({tag, "_lo"}, 64'(hilo_out), 64'(exp_lo));
      hilo_sel = 1'b1; #1;
      chk({tag, "_hi"}, 64'(hilo_out), 64'(exp_hi));
      hilo_sel = 1'b0; #1;
   endtask

   // Issues one MULTU with start held until stall falls; ends in the DONE cycle.
   task automatic run_mult(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                           input int chg_at, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input bit keep_start);
      int waitc;
      int cyc;
      a = ta; b = tb_v; start = 1'b1; #1;
      waitc = 0;
      while (!stall && waitc < 5) begin
         @(negedge clk);
         waitc++;
      end
      cyc = 0;
      while (stall && cyc < 100) begin
         if (cyc == chg_at) begin
            a = 32'hDEADBEEF;
            b = 32'hDEADBEEF;
         end
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk({tag, "_busy_run"}, 64'(busy), 64'd1);
      end
      $display("run %s: a=%0h b=%0h stall_cycles=%0d", tag, ta, tb_v, cyc);
      chk({tag, "_stall_len"}, 64'(cyc), 64'd33);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_busy_done"}, 64'(busy), 64'd0);
      chk_hilo(tag, exp_hi, exp_lo);
      if (!keep_start) start = 1'b0;
   endtask

   initial begin
      int d0;
      errors = 0; checks = 0; done_cnt = 0;
      rst = 1'b0; start = 1'b0; flush = 1'b0; a = '0; b = '0; hilo_sel = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state; stall follows start combinationally even in reset.
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_stall0", 64'(stall), 64'd0);
      start = 1'b1; #1;
      chk("rst_stall1", 64'(stall), 64'd1);
      start = 1'b0; #1;
      chk_hilo("rst", 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      run_mult("m3x5", 32'd3, 32'd5, -1, 32'h0, 32'd15, 1'b0);
      @(negedge clk);
      chk("m3x5_done_clr", 64'(done), 64'd0);

      run_mult("mff", 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      @(negedge clk);

      run_mult("mzero", 32'h12345678, 32'h0, -1, 32'h0, 32'h0, 1'b0);
      @(negedge clk);

      run_mult("m7x9chg", 32'd7, 32'd9, 3, 32'h0, 32'd63, 1'b0);
      @(negedge clk);

      // Back-to-back: second op's operands appear at the DONE edge.
      d0 = done_cnt;
      run_mult("b2b_1", 32'd2, 32'd3, -1, 32'h0, 32'd6, 1'b1);
      run_mult("b2b_2", 32'd4, 32'd5, -1, 32'h0, 32'd20, 1'b0);
      repeat (3) @(negedge clk);
      chk("b2b_done_pulses", 64'(done_cnt - d0), 64'd2);

      // Async reset 10 cycles into RUN.
      a = 32'd3; b = 32'd5; start = 1'b1;
      repeat (11) @(negedge clk);
      chk("rstmid_busy_pre", 64'(busy), 64'd1);
      d0 = done_cnt;
      rst = 1'b0; #1;
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_stall_start", 64'(stall), 64'd1);
      chk_hilo("rstmid", 32'h0, 32'h0);
      start = 1'b0; #1;
      chk("rstmid_stall_nostart", 64'(stall), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
      $display("rst-mid-run: done pulses=%0d", done_cnt - d0);

      run_mult("pre_flush", 32'd3, 32'd5, -1, 32'h0, 32'd15, 1'b0);
      @(negedge clk);

      // Flush 10 cycles into RUN.
      d0 = done_cnt;
      a = 32'd100; b = 32'd100; start = 1'b1;
      repeat (11) @(negedge clk);
      flush = 1'b1; start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_stall", 64'(stall), 64'd0);
      repeat (40) @(negedge clk);
      chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
      chk_hilo("flush", 32'h0, 32'd15);
      $display("flush-mid-run: done pulses=%0d lo=%0d", done_cnt - d0, hilo_out);

      // flush together with start in IDLE must not launch.
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("flush_idle_busy2", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
